l2_mem_responder: RTL

Main-memory responder on the L2 cache's downstream `mem_*` interface. It services line reads and line writes from the L2 with a configurable fixed latency. It holds a 128-bit-line backing store and presents a single-cycle `mem_ready` pulse. Read data stays stable afterwards, so an L2 that registers `mem_ready` before consuming `mem_rdata` sees valid data.

---
 rtl/l2_mem_pkg.sv | 8 +
 rtl/l2_mem_array.sv | 18 +
 rtl/l2_mem_responder.sv | 71 +++++++
 3 files changed

// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared widths, state encoding and line/address types for the L2 memory responder
package l2_mem_pkg;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} l2_mem_state_t;
  typedef logic [DEF_DATA_W-1:0] line_t;
  typedef logic [DEF_ADDR_W-1:0] laddr_t;
endpackage

// File: rtl/l2_mem_array.sv
// l2_mem_array: single-port line store, synchronous write, combinational read, no reset
module l2_mem_array
  import l2_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/l2_mem_responder.sv
// l2_mem_responder: fixed-latency main-memory model behind the L2 mem_* port
module l2_mem_responder
  import l2_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 8,
  parameter int WR_LAT     = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);
  localparam int MAX_LAT = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT) < 1 ? 1 : $clog2(MAX_LAT);
  l2_mem_state_t state_q, state_d;
  logic [LAT_W-1:0] cnt_q;
  logic op_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q, rdata;
  logic accept, fire;
  logic unused_hi;
  assign unused_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];
  always_comb begin
    accept  = state_q == IDLE && (mem_read || mem_write);
    fire    = state_q == BUSY && cnt_q == '0;
    state_d = accept ? BUSY : fire ? DONE : state_q == BUSY ? BUSY : IDLE;
  end
  always_ff @(posedge clk or posedge proc_reset)
    if (proc_reset) state_q <= IDLE;
    else state_q <= state_d;
  // the array is sampled at completion, so a read sees every earlier committed write
  always_ff @(posedge clk or posedge proc_reset)
    if (proc_reset) begin
      cnt_q     <= '0;
      op_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      if (accept) begin
        op_q    <= mem_write;
        idx_q   <= mem_addr[DEPTH_LOG2-1:0];
        wdata_q <= mem_wdata;
        cnt_q   <= mem_write ? LAT_W'(WR_LAT - 1) : LAT_W'(RD_LAT - 1);
      end else if (state_q == BUSY && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      mem_ready <= fire;
      if (fire && !op_q) mem_rdata <= rdata;
      if (fire && !op_q && ~&rd_cnt) rd_cnt <= rd_cnt + 1'b1;
      if (fire && op_q && ~&wr_cnt) wr_cnt <= wr_cnt + 1'b1;
    end
  l2_mem_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (fire && op_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );
endmodule
